// File: rtl/mux_scan_pkg.sv
// Shared state encoding and default geometry for the mux select scanner.
package mux_scan_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} scan_state_t;

  localparam int N_IN_DEF  = 4;
  localparam int SEL_W_DEF = 2;

endpackage

// File: rtl/mux_sel_scanner_if.sv
// Select/readback and word-handshake bundle between the scanner, the mux stage and the display stage.
// Optional macro SCAN_PARITY_EN adds the word_par signal.
interface mux_sel_scanner_if
  import mux_scan_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic [SEL_W-1:0] S;
  logic             O;
  logic [N_IN-1:0]  word_o;
  logic             word_valid;
  logic             word_ready;
`ifdef SCAN_PARITY_EN
  logic             word_par;
`endif

  modport master (
    output S,
    input  O,
    output word_o,
    output word_valid,
    input  word_ready
`ifdef SCAN_PARITY_EN
    ,
    output word_par
`endif
  );

  modport slave (
    input  S,
    output O,
    input  word_o,
    input  word_valid,
    output word_ready
`ifdef SCAN_PARITY_EN
    ,
    input  word_par
`endif
  );

endinterface

// File: rtl/scan_dwell_cnt.sv
// Settle-interval down-counter: load starts a DWELL-cycle window, done marks its final cycle.
module scan_dwell_cnt #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(DWELL + 1);
  // Loading DWELL-1 makes done appear on the DWELL-th enabled cycle after the load.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mux_sel_scanner.sv
// Steps the mux select through every input, samples its output after a settle interval and hands the packed word downstream.
// Optional macro SCAN_PARITY_EN adds a registered even-parity bit (word_par) alongside word_o.
module mux_sel_scanner
  import mux_scan_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              cont,
  output logic              busy,
  mux_sel_scanner_if.master bus
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_IN - 1);

  scan_state_t      state;
  scan_state_t      next_state;
  logic [SEL_W-1:0] sel;
  logic [N_IN-1:0]  shreg;
  logic [N_IN-1:0]  shreg_next;
  logic [N_IN-1:0]  word_q;
  logic             valid_q;
  logic             busy_q;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_done;
  logic             handshake;
  logic             last_sample;

  scan_dwell_cnt #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .rstn (rstn),
    .load (cnt_load),
    .en   (cnt_en),
    .done (cnt_done)
  );

  always_comb begin
    next_state      = state;
    cnt_load        = 1'b0;
    cnt_en          = 1'b0;
    handshake       = valid_q && bus.word_ready;
    last_sample     = (state == SAMPLE) && (sel == LAST_SEL);
    shreg_next      = shreg;
    shreg_next[sel] = bus.O;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SETTLE;
          cnt_load   = 1'b1;
        end
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          next_state = SAMPLE;
        end
      end
      SAMPLE: begin
        if (sel == LAST_SEL) begin
          next_state = HOLD;
        end else begin
          next_state = SETTLE;
          cnt_load   = 1'b1;
        end
      end
      HOLD: begin
        if (handshake) begin
          if (cont) begin
            next_state = SETTLE;
            cnt_load   = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != IDLE);
    end
  end

  // Select only advances out of SAMPLE and returns to 0 solely through the handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel <= '0;
    end else if ((state == SAMPLE) && (sel != LAST_SEL)) begin
      sel <= sel + SEL_W'(1);
    end else if ((state == HOLD) && handshake) begin
      sel <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg  <= '0;
      word_q <= '0;
    end else begin
      if (state == SAMPLE) begin
        shreg <= shreg_next;
      end
      if (last_sample) begin
        word_q <= shreg_next;
      end
    end
  end

  // Valid rises one cycle after HOLD entry, so word_o has settled a full cycle before it is offered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
    end else if (handshake) begin
      valid_q <= 1'b0;
    end else if (state == HOLD) begin
      valid_q <= 1'b1;
    end
  end

`ifdef SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q <= 1'b0;
    end else if (last_sample) begin
      par_q <= ^shreg_next;
    end
  end

  assign bus.word_par = par_q;
`endif

  assign bus.S          = sel;
  assign bus.word_o     = word_q;
  assign bus.word_valid = valid_q;
  assign busy           = busy_q;

endmodule
